mem_responder: RTL and testbench

- Main-memory bus responder: the target end of the RD / WRMain / ACK handshake driven by the microcoded control unit.
- Accepts word read/write requests on the A (address) and B (write data) buses and inserts a programmable number of wait states.
- Returns read data on a registered output bus and pulses ACK once per completed access.
- Intended as a drop-in variable-latency memory model for the datapath/control system, so control stall behaviour is exercised under non-zero latency.

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Variable-latency main-memory responder for the RD / WRMain / ACK handshake.
// Optional misaligned-access trap enabled by defining MEM_RESPONDER_MISALIGN_TRAP_EN.
module mem_responder #(
    parameter int DATAWIDTH_BUS         = 32,
    parameter int DATAWIDTH_MEM_ADDRESS = 10,
    parameter int WAIT_STATES           = 2
) (
    input  logic                     MEM_RESPONDER_CLOCK_50,
    input  logic                     MEM_RESPONDER_ResetInHigh_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_RESPONDER_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEM_RESPONDER_B_InBus,
    input  logic                     MEM_RESPONDER_RD_In,
    input  logic                     MEM_RESPONDER_WRMain_In,
    output logic                     MEM_RESPONDER_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_RESPONDER_Data_OutBus
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    ,
    output logic                     MEM_RESPONDER_Misalign_Out
`endif
);

    localparam int DEPTH = 2 ** DATAWIDTH_MEM_ADDRESS;
    localparam int HI_W  = DATAWIDTH_BUS - DATAWIDTH_MEM_ADDRESS - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                           state_r;
    state_t                           state_next_s;
    logic                             accept_s;
    logic                             access_s;
    logic [7:0]                       cnt_r;
    logic [DATAWIDTH_MEM_ADDRESS-1:0] idx_r;
    logic [DATAWIDTH_BUS-1:0]         wdata_r;
    logic                             op_wr_r;
    logic                             in_range_r;
    logic                             ack_r;
    logic [DATAWIDTH_BUS-1:0]         data_out_r;
    logic                             suppress_s;
    logic                             mem_we_s;
    logic [DATAWIDTH_MEM_ADDRESS-1:0] addr_idx_s;
    logic                             addr_in_range_s;
    logic [DATAWIDTH_BUS-1:0]         mem_r [0:DEPTH-1];

    assign addr_idx_s      = MEM_RESPONDER_A_InBus[DATAWIDTH_MEM_ADDRESS+1:2];
    assign addr_in_range_s = (MEM_RESPONDER_A_InBus[DATAWIDTH_BUS-1:DATAWIDTH_MEM_ADDRESS+2]
                              == {HI_W{1'b0}});

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    logic misalign_r;
    logic misalign_out_r;

    assign suppress_s                 = misalign_r;
    assign MEM_RESPONDER_Misalign_Out = misalign_out_r;

    // Misalign flag latched at accept, reported only alongside ACK
    always_ff @(posedge MEM_RESPONDER_CLOCK_50) begin
        if (MEM_RESPONDER_ResetInHigh_In) begin
            misalign_r     <= 1'b0;
            misalign_out_r <= 1'b0;
        end else begin
            if (accept_s) begin
                misalign_r <= (MEM_RESPONDER_A_InBus[1:0] != 2'b00);
            end else begin
                misalign_r <= misalign_r;
            end
            misalign_out_r <= (state_next_s == ST_ACK) && misalign_r;
        end
    end
`else
    logic unused_addr_lsb_s;

    assign suppress_s        = 1'b0;
    assign unused_addr_lsb_s = ^MEM_RESPONDER_A_InBus[1:0];
`endif

    // State register
    always_ff @(posedge MEM_RESPONDER_CLOCK_50) begin
        if (MEM_RESPONDER_ResetInHigh_In) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; GAP swallows one cycle so a held request level is not re-accepted
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MEM_RESPONDER_RD_In || MEM_RESPONDER_WRMain_In) begin
                    state_next_s = ST_WAIT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_ACK;
                    access_s     = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACK:  state_next_s = ST_GAP;
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // A write landing on the reset edge is abandoned along with the FSM
    assign mem_we_s = access_s && op_wr_r && in_range_r && !suppress_s
                      && !MEM_RESPONDER_ResetInHigh_In;

    // Request latch, wait counter, read data and ACK registers
    always_ff @(posedge MEM_RESPONDER_CLOCK_50) begin
        if (MEM_RESPONDER_ResetInHigh_In) begin
            cnt_r      <= 8'd0;
            idx_r      <= {DATAWIDTH_MEM_ADDRESS{1'b0}};
            wdata_r    <= {DATAWIDTH_BUS{1'b0}};
            op_wr_r    <= 1'b0;
            in_range_r <= 1'b0;
            ack_r      <= 1'b0;
            data_out_r <= {DATAWIDTH_BUS{1'b0}};
        end else begin
            if (accept_s) begin
                cnt_r      <= 8'(WAIT_STATES);
                idx_r      <= addr_idx_s;
                wdata_r    <= MEM_RESPONDER_B_InBus;
                op_wr_r    <= MEM_RESPONDER_WRMain_In;
                in_range_r <= addr_in_range_s;
            end else if ((state_r == ST_WAIT) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            ack_r <= (state_next_s == ST_ACK);
            if (access_s && !op_wr_r && !suppress_s) begin
                data_out_r <= in_range_r ? mem_r[idx_r] : {DATAWIDTH_BUS{1'b0}};
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge MEM_RESPONDER_CLOCK_50) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    assign MEM_RESPONDER_ACK_Out     = ack_r;
    assign MEM_RESPONDER_Data_OutBus = data_out_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand-written latency/reset sequences.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, a0, b0;
    logic        rd, wr, rd0, wr0;
    logic        ack, ack0;
    logic [31:0] dout, dout0;
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    logic        mis, mis0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATAWIDTH_BUS(32), .DATAWIDTH_MEM_ADDRESS(10), .WAIT_STATES(2)) dut (
        .MEM_RESPONDER_CLOCK_50      (clk),
        .MEM_RESPONDER_ResetInHigh_In(rst),
        .MEM_RESPONDER_A_InBus       (a),
        .MEM_RESPONDER_B_InBus       (b),
        .MEM_RESPONDER_RD_In         (rd),
        .MEM_RESPONDER_WRMain_In     (wr),
        .MEM_RESPONDER_ACK_Out       (ack),
        .MEM_RESPONDER_Data_OutBus   (dout)
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
        ,
        .MEM_RESPONDER_Misalign_Out  (mis)
`endif
    );

    mem_responder #(.DATAWIDTH_BUS(32), .DATAWIDTH_MEM_ADDRESS(10), .WAIT_STATES(0)) dut0 (
        .MEM_RESPONDER_CLOCK_50      (clk),
        .MEM_RESPONDER_ResetInHigh_In(rst),
        .MEM_RESPONDER_A_InBus       (a0),
        .MEM_RESPONDER_B_InBus       (b0),
        .MEM_RESPONDER_RD_In         (rd0),
        .MEM_RESPONDER_WRMain_In     (wr0),
        .MEM_RESPONDER_ACK_Out       (ack0),
        .MEM_RESPONDER_Data_OutBus   (dout0)
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
        ,
        .MEM_RESPONDER_Misalign_Out  (mis0)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          pulse;
        int          exp_ack;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request in cycle 0; report the ACK cycle (-1 on timeout) and outputs seen then.
    task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                              input logic [31:0] data, input bit pulse,
                              output int ack_cyc, output logic [31:0] d_at_ack,
                              output logic mis_at_ack);
        rd = r; wr = w; a = addr; b = data;
        ack_cyc = -1; d_at_ack = 32'h0; mis_at_ack = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (pulse && c == 1) begin
                rd = 1'b0; wr = 1'b0;
            end
            if (ack) begin
                ack_cyc  = c;
                d_at_ack = dout;
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
                mis_at_ack = mis;
`endif
                break;
            end
        end
        rd = 1'b0; wr = 1'b0;
        tick;
        check("ack_one_wide", 32'(ack), 32'd0);
        tick;
        check("ack_gap_low", 32'(ack), 32'd0);
    endtask

    initial begin
        int          ac;
        logic [31:0] d;
        logic        m;
        int          acks[$];
        bit          spurious;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; a = 32'h0; b = 32'h0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = 32'h0; b0 = 32'h0;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 4, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 4, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 4, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 4, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b0, 4, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4, 32'hA5A5_0001};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h7777_8888, 1'b0, 4, 32'hA5A5_0001};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 4, 32'h7777_8888};
        vecs[8]  = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 1'b0, 4, 32'h0000_0000};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 4, 32'h0000_0000};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0030, 32'h3C3C_3C3C, 1'b1, 4, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 1'b1, 4, 32'h3C3C_3C3C};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 4, 32'hDEAD_BEEF};

        tick; tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_dout", dout, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].pulse, ac, d, m);
            check($sformatf("vec%0d_ack_cycle", i), 32'(ac), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
        end

        // RD level held for 20 cycles: ACK every 6 cycles, never back to back
        rd = 1'b1; a = 32'h0000_0010;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (ack) acks.push_back(c);
        end
        rd = 1'b0;
        check("held_rd_ack_count", 32'(acks.size()), 32'd3);
        if (acks.size() == 3) begin
            check("held_rd_ack0", 32'(acks[0]), 32'd4);
            check("held_rd_ack1", 32'(acks[1]), 32'd10);
            check("held_rd_ack2", 32'(acks[2]), 32'd16);
        end
        check("held_rd_dout", dout, 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) tick;

        // Reset in cycle 2 of a write: abandoned, no ACK, old data kept
        wr = 1'b1; a = 32'h0000_0020; b = 32'hCAFE_F00D;
        tick; tick;
        rst = 1'b1;
        tick;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dout", 32'(dout), 32'h0);
        rst = 1'b0; wr = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (ack) spurious = 1'b1;
        end
        check("rst_mid_no_ack", 32'(spurious), 32'd0);
        run_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, ac, d, m);
        check("rst_mid_rd_ack", 32'(ac), 32'd4);
        check("rst_mid_rd_data", d, 32'h1111_2222);

        // RD and WRMain together: write wins
        run_access(1'b1, 1'b1, 32'h0000_0024, 32'h55AA_55AA, 1'b0, ac, d, m);
        check("both_ack", 32'(ac), 32'd4);
        check("both_dout_kept", d, 32'h1111_2222);
        run_access(1'b1, 1'b0, 32'h0000_0024, 32'h0, 1'b0, ac, d, m);
        check("both_rd_data", d, 32'h55AA_55AA);

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
        run_access(1'b0, 1'b1, 32'h0000_0013, 32'h9999_9999, 1'b0, ac, d, m);
        check("mis_ack", 32'(ac), 32'd4);
        check("mis_flag", 32'(m), 32'd1);
        check("mis_dout_kept", d, 32'h55AA_55AA);
        check("mis_flag_after", 32'(mis), 32'd0);
        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, ac, d, m);
        check("mis_word_unchanged", d, 32'hDEAD_BEEF);
        check("mis_flag_aligned", 32'(m), 32'd0);
`endif

        // Zero wait states: ACK in cycle 2
        wr0 = 1'b1; a0 = 32'h0000_0040; b0 = 32'hFEED_FACE;
        ac = -1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (ack0) begin
                ac = c;
                break;
            end
        end
        wr0 = 1'b0;
        check("ws0_wr_ack", 32'(ac), 32'd2);
        check("ws0_wr_dout", dout0, 32'h0);
        tick; tick;
        rd0 = 1'b1;
        ac = -1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (ack0) begin
                ac = c;
                break;
            end
        end
        rd0 = 1'b0;
        check("ws0_rd_ack", 32'(ac), 32'd2);
        check("ws0_rd_data", dout0, 32'hFEED_FACE);
        tick;
        check("ws0_ack_one_wide", 32'(ack0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
